layer_sequencer: RTL and testbench

- Upstream control stage for the convolution accelerator top level.
- Holds a programmable table of per-layer configurations and steps through it in order.
- For each layer it drives the layer-config buses and a one-cycle start pulse into the accelerator, then waits for the accelerator's done.
- Toggles a ping-pong buffer select between layers so each layer's OFM buffer becomes the next layer's IFM buffer.

---
 rtl/layer_seq_pkg.sv | 59 +++++
 rtl/layer_cfg_table.sv | 25 ++
 rtl/layer_sequencer.sv | 166 ++++++++++++++++
 tb/tb_layer_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_seq_pkg.sv
// Shared types and config-field layout for the layer sequencer.
// Packed entry: {ups, mp_stride, mp_mode, n_filt, ksize, ifm_ch, ifm_size}.
package layer_seq_pkg;

  localparam int CFG_W = 37;

  localparam int IFM_SIZE_LSB = 0;
  localparam int IFM_SIZE_W   = 9;
  localparam int IFM_CH_LSB   = 9;
  localparam int IFM_CH_W     = 11;
  localparam int KSIZE_LSB    = 20;
  localparam int KSIZE_W      = 2;
  localparam int NFILT_LSB    = 22;
  localparam int NFILT_W      = 11;
  localparam int MPMODE_LSB   = 33;
  localparam int MPSTR_LSB    = 34;
  localparam int MPSTR_W      = 2;
  localparam int UPS_LSB      = 36;

  typedef logic [CFG_W-1:0] cfg_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_NEXT,
    S_FINISH
  } state_t;

  function automatic logic [IFM_SIZE_W-1:0] f_ifm_size(cfg_t c);
    return c[IFM_SIZE_LSB +: IFM_SIZE_W];
  endfunction

  function automatic logic [IFM_CH_W-1:0] f_ifm_ch(cfg_t c);
    return c[IFM_CH_LSB +: IFM_CH_W];
  endfunction

  function automatic logic [KSIZE_W-1:0] f_ksize(cfg_t c);
    return c[KSIZE_LSB +: KSIZE_W];
  endfunction

  function automatic logic [NFILT_W-1:0] f_nfilt(cfg_t c);
    return c[NFILT_LSB +: NFILT_W];
  endfunction

  function automatic logic f_mp_mode(cfg_t c);
    return c[MPMODE_LSB];
  endfunction

  function automatic logic [MPSTR_W-1:0] f_mp_str(cfg_t c);
    return c[MPSTR_LSB +: MPSTR_W];
  endfunction

  function automatic logic f_ups(cfg_t c);
    return c[UPS_LSB];
  endfunction

endpackage

// File: rtl/layer_cfg_table.sv
// Per-layer configuration register file.
// Synchronous write, asynchronous read; contents are not reset.
module layer_cfg_table
  import layer_seq_pkg::*;
#(
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  cfg_t          i_wdata,
  input  logic [AW-1:0] i_raddr,
  output cfg_t          o_rdata
);

  cfg_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/layer_sequencer.sv
// Steps the accelerator through a table of per-layer configs.
// LAYER_SEQUENCER_PERF_EN adds per-layer cycle counters.
module layer_sequencer
  import layer_seq_pkg::*;
#(
  parameter  int MAX_LAYERS = 32,
  localparam int LIDX_W     = $clog2(MAX_LAYERS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [LIDX_W-1:0] cfg_waddr,
  input  logic [CFG_W-1:0]  cfg_wdata,
  input  logic [LIDX_W:0]   num_layers,
  input  logic              run,
  input  logic              abort,
  input  logic              layer_done,
  output logic              start,
  output logic [8:0]        ifm_size,
  output logic [10:0]       ifm_channel,
  output logic [1:0]        kernel_size,
  output logic [10:0]       num_filter,
  output logic              maxpool_mode,
  output logic [1:0]        maxpool_stride,
  output logic              upsample_mode,
  output logic              buf_sel,
  output logic [LIDX_W-1:0] cur_layer,
  output logic              busy,
  output logic              all_done
`ifdef LAYER_SEQUENCER_PERF_EN
  ,
  output logic [31:0]       layer_cycles,
  output logic [31:0]       last_layer_cycles
`endif
);

  localparam logic [LIDX_W:0] MAXN = (LIDX_W+1)'(MAX_LAYERS);

  state_t            r_state, w_state_nxt;
  logic [LIDX_W-1:0] r_idx;
  logic [LIDX_W:0]   r_count, w_count;
  cfg_t              r_cfg, w_rd_cfg;
  logic              r_buf, r_start, r_done, r_busy;
  logic              w_abort, w_last, w_we;
  logic              w_go, w_load, w_adv;
  logic              w_start, w_done, w_busy;

  assign w_abort = abort && (r_state != S_IDLE);
  assign w_last  = ({1'b0, r_idx} + (LIDX_W+1)'(1)) == r_count;
  assign w_count = (num_layers > MAXN) ? MAXN : num_layers;
  assign w_we    = cfg_we && (r_state == S_IDLE)
                && ({1'b0, cfg_waddr} < MAXN);

  layer_cfg_table #(.DEPTH(MAX_LAYERS)) u_tbl (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (cfg_waddr),
    .i_wdata (cfg_wdata),
    .i_raddr (r_idx),
    .o_rdata (w_rd_cfg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (run)
            w_state_nxt = (num_layers == '0) ? S_FINISH : S_LOAD;
        end
        S_LOAD:   w_state_nxt = S_START;
        S_START:  w_state_nxt = S_WAIT;
        S_WAIT:   if (layer_done) w_state_nxt = S_NEXT;
        S_NEXT:   w_state_nxt = w_last ? S_FINISH : S_LOAD;
        S_FINISH: w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_go    = 1'b0;
    w_load  = 1'b0;
    w_adv   = 1'b0;
    w_start = 1'b0;
    w_done  = 1'b0;
    w_busy  = (r_state != S_IDLE);
    if (!w_abort) begin
      unique case (r_state)
        S_IDLE:   w_go    = run && (num_layers != '0);
        S_LOAD:   w_load  = 1'b1;
        S_START:  w_start = 1'b1;
        S_NEXT:   w_adv   = 1'b1;
        S_FINISH: w_done  = 1'b1;
        default:  ;
      endcase
    end
  end

  // Pulses and busy are registered so they trail the state by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_count <= '0;
      r_cfg   <= '0;
      r_buf   <= 1'b0;
      r_start <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_start <= w_start;
      r_done  <= w_done;
      r_busy  <= w_busy;
      if (w_go) begin
        r_idx   <= '0;
        r_count <= w_count;
      end else if (w_adv && !w_last) begin
        r_idx <= r_idx + 1'b1;
      end
      if (w_load) r_cfg <= w_rd_cfg;
      if (w_adv)  r_buf <= ~r_buf;
    end
  end

  assign start          = r_start && !abort;
  assign all_done       = r_done;
  assign busy           = r_busy;
  assign buf_sel        = r_buf;
  assign cur_layer      = r_idx;
  assign ifm_size       = f_ifm_size(r_cfg);
  assign ifm_channel    = f_ifm_ch(r_cfg);
  assign kernel_size    = f_ksize(r_cfg);
  assign num_filter     = f_nfilt(r_cfg);
  assign maxpool_mode   = f_mp_mode(r_cfg);
  assign maxpool_stride = f_mp_str(r_cfg);
  assign upsample_mode  = f_ups(r_cfg);

`ifdef LAYER_SEQUENCER_PERF_EN
  logic [31:0] r_cyc, r_last_cyc, w_cyc_inc;

  assign w_cyc_inc = (r_cyc == '1) ? r_cyc : r_cyc + 32'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc      <= '0;
      r_last_cyc <= '0;
    end else begin
      if (r_state == S_START)     r_cyc <= '0;
      else if (r_state == S_WAIT) r_cyc <= w_cyc_inc;
      if (r_state == S_WAIT && layer_done && !w_abort)
        r_last_cyc <= w_cyc_inc;
    end
  end

  assign layer_cycles      = r_cyc;
  assign last_layer_cycles = r_last_cyc;
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer with an expected-config scoreboard.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_layer_sequencer;
  import layer_seq_pkg::*;

  localparam int ML = 32;
  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [LW-1:0] cfg_waddr = '0;
  logic [CFG_W-1:0] cfg_wdata = '0;
  logic [LW:0]   num_layers = '0;
  logic          run = 1'b0;
  logic          abort = 1'b0;
  logic          layer_done = 1'b0;
  logic          start;
  logic [8:0]    ifm_size;
  logic [10:0]   ifm_channel;
  logic [1:0]    kernel_size;
  logic [10:0]   num_filter;
  logic          maxpool_mode;
  logic [1:0]    maxpool_stride;
  logic          upsample_mode;
  logic          buf_sel;
  logic [LW-1:0] cur_layer;
  logic          busy;
  logic          all_done;

  layer_sequencer #(.MAX_LAYERS(ML)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_we         (cfg_we),
    .cfg_waddr      (cfg_waddr),
    .cfg_wdata      (cfg_wdata),
    .num_layers     (num_layers),
    .run            (run),
    .abort          (abort),
    .layer_done     (layer_done),
    .start          (start),
    .ifm_size       (ifm_size),
    .ifm_channel    (ifm_channel),
    .kernel_size    (kernel_size),
    .num_filter     (num_filter),
    .maxpool_mode   (maxpool_mode),
    .maxpool_stride (maxpool_stride),
    .upsample_mode  (upsample_mode),
    .buf_sel        (buf_sel),
    .cur_layer      (cur_layer),
    .busy           (busy),
    .all_done       (all_done)
  );

  always #5 clk = ~clk;

  wire [CFG_W-1:0] obs_cfg = {upsample_mode, maxpool_stride,
    maxpool_mode, num_filter, kernel_size, ifm_channel, ifm_size};

  int checks = 0;
  int errors = 0;
  int spur = 0;
  logic exp_buf = 1'b0;
  logic [CFG_W-1:0] tbl [ML];
  logic [LW+CFG_W-1:0] sb_q [$];

  function automatic logic [CFG_W-1:0] mk(
    input logic ups, input logic [1:0] mps, input logic mpm,
    input logic [10:0] nf, input logic [1:0] ks,
    input logic [10:0] ic, input logic [8:0] is);
    return {ups, mps, mpm, nf, ks, ic, is};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_cfg(input logic [LW-1:0] a,
                           input logic [CFG_W-1:0] d, input bit acc);
    cfg_we = 1'b1;
    cfg_waddr = a;
    cfg_wdata = d;
    if (acc) tbl[a] = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic run_seq(input logic [LW:0] n);
    int m;
    m = (int'(n) > ML) ? ML : int'(n);
    run = 1'b1;
    num_layers = n;
    for (int i = 0; i < m; i++) sb_q.push_back({LW'(i), tbl[i]});
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic check_start_now(input string tag);
    logic [LW+CFG_W-1:0] e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_has_entry"}, 64'(sb_q.size()), 64'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_cfg"}, 64'(obs_cfg), 64'(e[CFG_W-1:0]));
      chk({tag, "_cur"}, 64'(cur_layer), 64'(e[CFG_W +: LW]));
      chk({tag, "_buf"}, 64'(buf_sel), 64'(exp_buf));
    end
  endtask

  task automatic wait_start(input string tag, input int lat);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      layer_done = 1'b0;
      n++;
    end while (start !== 1'b1 && n < 40);
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    if (start === 1'b1) check_start_now(tag);
  endtask

  task automatic wait_done(input string tag, input int lat);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (all_done !== 1'b1 && n < 40);
    chk({tag, "_done_lat"}, 64'(n), 64'(lat));
    chk({tag, "_busy_at_done"}, 64'(busy), 64'd1);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(all_done), 64'd0);
    chk({tag, "_busy_after"}, 64'(busy), 64'd0);
    chk({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
  endtask

  task automatic pulse_done();
    exp_buf = ~exp_buf;
    layer_done = 1'b1;
    @(negedge clk);
    layer_done = 1'b0;
  endtask

  task automatic idle_wait(input int n);
    repeat (n) begin
      @(negedge clk);
      if (start || all_done) spur++;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_start"}, 64'(start), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_alldone"}, 64'(all_done), 64'd0);
    chk({tag, "_cur"}, 64'(cur_layer), 64'd0);
    chk({tag, "_buf"}, 64'(buf_sel), 64'd0);
    chk({tag, "_cfg"}, 64'(obs_cfg), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r64;
    repeat (2) @(negedge clk);
    chk_reset("rst");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < ML; i++) begin
      r64 = {$urandom(), $urandom()};
      write_cfg(LW'(i), r64[CFG_W-1:0], 1'b1);
    end
    write_cfg(5'd0, mk(0, 0, 0, 32, 3, 3, 416), 1'b1);
    write_cfg(5'd1, mk(0, 2, 1, 64, 3, 32, 208), 1'b1);
    write_cfg(5'd2, mk(1, 0, 0, 128, 1, 64, 13), 1'b1);

    run_seq(6'd0);
    chk("zero_start", 64'(start), 64'd0);
    wait_done("zero", 1);
    chk("zero_buf", 64'(buf_sel), 64'd0);

    run_seq(6'd3);
    wait_start("s3_l0", 2);
    idle_wait(19);
    pulse_done();
    wait_start("s3_l1", 3);
    idle_wait(19);
    pulse_done();
    wait_start("s3_l2", 3);
    idle_wait(19);
    pulse_done();
    wait_done("s3", 2);
    chk("s3_buf_end", 64'(buf_sel), 64'(exp_buf));

    run_seq(6'd1);
    layer_done = 1'b1;
    @(negedge clk);
    wait_start("spur", 1);
    write_cfg(5'd0, mk(1, 3, 1, 11'h7ff, 2, 11'h555, 9'h1aa), 1'b0);
    idle_wait(10);
    chk("spur_busy", 64'(busy), 64'd1);
    pulse_done();
    wait_done("spur", 2);

    cfg_we = 1'b1;
    cfg_waddr = 5'd1;
    cfg_wdata = mk(1, 1, 1, 500, 2, 700, 300);
    tbl[1] = cfg_wdata;
    run_seq(6'd2);
    cfg_we = 1'b0;
    wait_start("rerun_l0", 2);
    pulse_done();
    wait_start("rerun_l1", 3);
    pulse_done();
    wait_done("rerun", 2);

    run_seq(6'd2);
    wait_start("ab_l0", 2);
    pulse_done();
    wait_start("ab_l1", 3);
    abort = 1'b1;
    #1;
    chk("ab_start_kill", 64'(start), 64'd0);
    @(negedge clk);
    abort = 1'b0;
    chk("ab_no_done0", 64'(all_done), 64'd0);
    @(negedge clk);
    chk("ab_idle", 64'(busy), 64'd0);
    chk("ab_no_done1", 64'(all_done), 64'd0);
    chk("ab_cur_kept", 64'(cur_layer), 64'd1);
    chk("ab_cfg_kept", 64'(obs_cfg), 64'(tbl[1]));
    chk("ab_buf_kept", 64'(buf_sel), 64'(exp_buf));
    idle_wait(5);
    run_seq(6'd1);
    wait_start("ab_restart", 2);
    pulse_done();
    wait_done("ab_restart", 2);

    run_seq(6'd3);
    wait_start("rs_l0", 2);
    pulse_done();
    wait_start("rs_l1", 3);
    idle_wait(3);
    rst_n = 1'b0;
    #1;
    chk_reset("rs_mid");
    exp_buf = 1'b0;
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run_seq(6'd1);
    wait_start("rs_restart", 2);
    pulse_done();
    wait_done("rs_restart", 2);

    run_seq(6'd40);
    for (int i = 0; i < ML; i++) begin
      wait_start("clamp", (i == 0) ? 2 : 3);
      pulse_done();
    end
    wait_done("clamp", 2);
    chk("clamp_buf", 64'(buf_sel), 64'(exp_buf));

    chk("no_spurious", 64'(spur), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
